decode_queue: RTL and testbench

- Parametrised, multi-lane successor to the single-instruction combinational decoder.
- Buffers up to WIDTH fetched instructions per cycle in a DEPTH-entry circular queue.
- Each cycle, pops up to WIDTH instructions from the head, decodes them and registers a decoded bundle with valid/ready handshakes on both sides.
- Adds three behaviours the single decoder does not have: illegal-opcode detection, branch-terminated bundles, and flush.
- Sits between fetch and the rename/issue stage of the out-of-order core.

---
 rtl/decode_queue.sv | 184 ++++++++++++++++++
 tb/tb_decode_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// Multi-lane decode queue: buffers fetched instructions in a circular queue and emits
// registered decoded bundles of up to WIDTH lanes, ending each bundle at the first branch.
module decode_queue #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int OP_W  = 3,
    parameter int RF_W  = 2,
    parameter int IMM_W = 4,
    parameter int PC_W  = 4,
    localparam int INST_LEN = OP_W + RF_W + IMM_W + RF_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [WIDTH-1:0]          in_valid,
    input  logic [WIDTH*INST_LEN-1:0] in_inst,
    input  logic [WIDTH*PC_W-1:0]     in_pc,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          out_valid,
    input  logic                      out_ready,
    output logic [WIDTH*PC_W-1:0]     out_pc,
    output logic [WIDTH*OP_W-1:0]     out_opcode,
    output logic [WIDTH*IMM_W-1:0]    out_rs1_imm,
    output logic [WIDTH*RF_W-1:0]     out_rs1,
    output logic [WIDTH*PC_W-1:0]     out_br_offset,
    output logic [WIDTH*RF_W-1:0]     out_rs2,
    output logic [WIDTH*RF_W-1:0]     out_rd,
    output logic [WIDTH-1:0]          out_wen,
    output logic [WIDTH-1:0]          out_rd_use_exe,
    output logic [WIDTH-1:0]          out_mem_valid,
    output logic [WIDTH-1:0]          out_mem_rdwt,
    output logic [WIDTH-1:0]          out_is_br,
    output logic [WIDTH-1:0]          out_illegal
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int LANE_W = $clog2(WIDTH + 1);

    localparam logic [OP_W-1:0] OP_LI  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LD  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ST  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BR  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_ILL = OP_W'(7);

    logic [INST_LEN-1:0] q_inst [DEPTH];
    logic [PC_W-1:0]     q_pc   [DEPTH];
    logic [PTR_W-1:0]    head, tail;
    logic [CNT_W-1:0]    count;

    logic                push, load, stop;
    logic [LANE_W-1:0]   pushed, popped;
    logic [WIDTH-1:0]    wr_en, take;
    logic [PTR_W-1:0]    wr_idx [WIDTH];
    int                  avail;

    logic [INST_LEN-1:0] c_inst    [WIDTH];
    logic [PC_W-1:0]     c_pc      [WIDTH];
    logic [OP_W-1:0]     c_opcode  [WIDTH];
    logic [RF_W-1:0]     c_rd      [WIDTH];
    logic [IMM_W-1:0]    c_rs1_imm [WIDTH];
    logic [RF_W-1:0]     c_rs2     [WIDTH];
    logic [WIDTH-1:0]    c_wen, c_use_exe, c_mem_valid, c_mem_rdwt, c_is_br, c_illegal;

    function automatic logic [PTR_W-1:0] wrap(input int base, input int offset);
        return PTR_W'((base + offset) % DEPTH);
    endfunction

    assign in_ready = (int'(count) + WIDTH) <= DEPTH;
    assign load     = !out_valid[0] || out_ready;

    // Valid input lanes are packed into consecutive slots starting at tail.
    always_comb begin
        push   = in_ready && (|in_valid) && !flush;
        pushed = '0;
        for (int i = 0; i < WIDTH; i++) begin
            wr_en[i]  = 1'b0;
            wr_idx[i] = wrap(int'(tail), int'(pushed));
            if (push && in_valid[i]) begin
                wr_en[i] = 1'b1;
                pushed   = pushed + LANE_W'(1);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            c_inst[j]      = q_inst[wrap(int'(head), j)];
            c_pc[j]        = q_pc[wrap(int'(head), j)];
            c_opcode[j]    = c_inst[j][RF_W+IMM_W+RF_W +: OP_W];
            c_rd[j]        = c_inst[j][RF_W+IMM_W +: RF_W];
            c_rs1_imm[j]   = c_inst[j][RF_W +: IMM_W];
            c_rs2[j]       = c_inst[j][0 +: RF_W];
            c_illegal[j]   = c_opcode[j] >= OP_ILL;
            c_wen[j]       = !c_illegal[j] && (c_opcode[j] == OP_LI || c_opcode[j] == OP_ADD ||
                                               c_opcode[j] == OP_MUL || c_opcode[j] == OP_LD);
            c_use_exe[j]   = c_opcode[j] == OP_LI || c_opcode[j] == OP_ADD || c_opcode[j] == OP_MUL;
            c_mem_valid[j] = !c_illegal[j] && (c_opcode[j] == OP_LD || c_opcode[j] == OP_ST);
            c_mem_rdwt[j]  = c_opcode[j] == OP_LD;
            c_is_br[j]     = !c_illegal[j] && c_opcode[j] == OP_BR;
        end
    end

    // Take head entries in order, stopping after the first branch so it ends the bundle.
    always_comb begin
        avail  = (int'(count) < WIDTH) ? int'(count) : WIDTH;
        popped = '0;
        stop   = 1'b0;
        take   = '0;
        for (int j = 0; j < WIDTH; j++) begin
            if (load && !flush && !stop && j < avail) begin
                take[j] = 1'b1;
                popped  = popped + LANE_W'(1);
                stop    = c_is_br[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= wrap(int'(head), int'(popped));
            tail  <= wrap(int'(tail), int'(pushed));
            count <= count + CNT_W'(pushed) - CNT_W'(popped);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (wr_en[i]) begin
                q_inst[wr_idx[i]] <= in_inst[i*INST_LEN +: INST_LEN];
                q_pc[wr_idx[i]]   <= in_pc[i*PC_W +: PC_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= '0;
            out_pc         <= '0;
            out_opcode     <= '0;
            out_rs1_imm    <= '0;
            out_rs1        <= '0;
            out_br_offset  <= '0;
            out_rs2        <= '0;
            out_rd         <= '0;
            out_wen        <= '0;
            out_rd_use_exe <= '0;
            out_mem_valid  <= '0;
            out_mem_rdwt   <= '0;
            out_is_br      <= '0;
            out_illegal    <= '0;
        end else if (flush) begin
            out_valid <= '0;
        end else if (load) begin
            out_valid <= take;
            for (int j = 0; j < WIDTH; j++) begin
                out_pc[j*PC_W +: PC_W]         <= take[j] ? c_pc[j] : '0;
                out_opcode[j*OP_W +: OP_W]     <= take[j] ? c_opcode[j] : '0;
                out_rs1_imm[j*IMM_W +: IMM_W]  <= take[j] ? c_rs1_imm[j] : '0;
                out_rs1[j*RF_W +: RF_W]        <= take[j] ? c_rs1_imm[j][RF_W-1:0] : '0;
                out_br_offset[j*PC_W +: PC_W]  <= take[j] ? c_rs1_imm[j][PC_W-1:0] : '0;
                out_rs2[j*RF_W +: RF_W]        <= take[j] ? c_rs2[j] : '0;
                out_rd[j*RF_W +: RF_W]         <= take[j] ? c_rd[j] : '0;
                out_wen[j]                     <= take[j] & c_wen[j];
                out_rd_use_exe[j]              <= take[j] & c_use_exe[j];
                out_mem_valid[j]               <= take[j] & c_mem_valid[j];
                out_mem_rdwt[j]                <= take[j] & c_mem_rdwt[j];
                out_is_br[j]                   <= take[j] & c_is_br[j];
                out_illegal[j]                 <= take[j] & c_illegal[j];
            end
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: directed fetch bundles with hand-written decode results.
module tb_decode_queue;

    typedef struct packed {
        logic [3:0] pc;
        logic [2:0] op;
        logic [1:0] rd;
        logic [3:0] imm;
        logic [1:0] rs2;
        logic       wen;
        logic       exe;
        logic       memv;
        logic       rdwt;
        logic       br;
        logic       ill;
    } lane_t;

    logic        clk, rst, flush;
    logic [1:0]  in_valid;
    logic [21:0] in_inst;
    logic [7:0]  in_pc;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic        out_ready;
    logic [7:0]  out_pc, out_rs1_imm, out_br_offset;
    logic [5:0]  out_opcode;
    logic [3:0]  out_rs1, out_rs2, out_rd;
    logic [1:0]  out_wen, out_rd_use_exe, out_mem_valid, out_mem_rdwt, out_is_br, out_illegal;

    int checks = 0;
    int errors = 0;
    logic [1:0] mask_q [$];
    lane_t      lane_q [$];

    decode_queue #(.WIDTH(2), .DEPTH(4), .OP_W(3), .RF_W(2), .IMM_W(4), .PC_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_rs1_imm(out_rs1_imm),
        .out_rs1(out_rs1), .out_br_offset(out_br_offset), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_wen(out_wen), .out_rd_use_exe(out_rd_use_exe), .out_mem_valid(out_mem_valid),
        .out_mem_rdwt(out_mem_rdwt), .out_is_br(out_is_br), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags order: wen, rd_use_exe, mem_valid, mem_rdwt, is_br, illegal
    function automatic lane_t L(input logic [3:0] pc, input logic [2:0] op, input logic [1:0] rd,
                                input logic [3:0] imm, input logic [1:0] rs2, input logic [5:0] flags);
        lane_t e;
        e.pc  = pc;
        e.op  = op;
        e.rd  = rd;
        e.imm = imm;
        e.rs2 = rs2;
        {e.wen, e.exe, e.memv, e.rdwt, e.br, e.ill} = flags;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one fetch bundle for a single edge; accepted lanes are recorded in order.
    task automatic applyStimulus(input logic [1:0] valid, input lane_t e0, input lane_t e1,
                                 input logic exp_ready, input logic record);
        in_valid = valid;
        in_inst  = {e1.op, e1.rd, e1.imm, e1.rs2, e0.op, e0.rd, e0.imm, e0.rs2};
        in_pc    = {e1.pc, e0.pc};
        checkOutput("in_ready at push", 64'(in_ready), 64'(exp_ready));
        if (record) begin
            if (valid[0]) lane_q.push_back(e0);
            if (valid[1]) lane_q.push_back(e1);
        end
        tick();
        in_valid = 2'b00;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((mask_q.size() != 0 || lane_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checkOutput("drain leftover expectations", 64'(mask_q.size() + lane_q.size()), 64'd0);
        mask_q.delete();
        lane_q.delete();
    endtask

    // Monitor: a bundle is consumed at the next edge when out_valid[0] and out_ready are high.
    always @(negedge clk) begin
        if (!rst && out_valid != 2'b00 && out_ready) begin
            checkOutput("out_valid contiguous", 64'(out_valid == 2'b10), 64'd0);
            if (mask_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected bundle actual out_valid=%b required none", out_valid);
            end else begin
                checkOutput("bundle out_valid", 64'(out_valid), 64'(mask_q.pop_front()));
                for (int j = 0; j < 2; j++) begin
                    if (out_valid[j]) begin : lane_chk
                        lane_t e;
                        if (lane_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL lane%0d unexpected actual valid required none", j);
                        end else begin
                            e = lane_q.pop_front();
                            checkOutput($sformatf("lane%0d fields", j),
                                64'({out_pc[j*4 +: 4], out_opcode[j*3 +: 3], out_rs1_imm[j*4 +: 4],
                                     out_rs1[j*2 +: 2], out_br_offset[j*4 +: 4], out_rs2[j*2 +: 2],
                                     out_rd[j*2 +: 2], out_wen[j], out_rd_use_exe[j], out_mem_valid[j],
                                     out_mem_rdwt[j], out_is_br[j], out_illegal[j]}),
                                64'({e.pc, e.op, e.imm, e.imm[1:0], e.imm[3:0], e.rs2, e.rd,
                                     e.wen, e.exe, e.memv, e.rdwt, e.br, e.ill}));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 2'b00; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        checkOutput("idle out_valid", 64'(out_valid), 64'd0);

        // LI + ADD as one full bundle
        mask_q.push_back(2'b11);
        applyStimulus(2'b11, L(4'd0, 3'd1, 2'd1, 4'd5, 2'd0, 6'b110000),
                             L(4'd1, 3'd2, 2'd2, 4'd1, 2'd1, 6'b110000), 1'b1, 1'b1);
        waitDrain(20);

        // BR in lane 0 ends its bundle; LD follows alone
        mask_q.push_back(2'b01);
        mask_q.push_back(2'b01);
        applyStimulus(2'b11, L(4'd2, 3'd6, 2'd0, 4'd3, 2'd0, 6'b000010),
                             L(4'd3, 3'd4, 2'd3, 4'd2, 2'd0, 6'b101100), 1'b1, 1'b1);
        waitDrain(20);

        // illegal opcode and store
        mask_q.push_back(2'b11);
        applyStimulus(2'b11, L(4'd4, 3'd7, 2'd1, 4'd9, 2'd2, 6'b000001),
                             L(4'd5, 3'd5, 2'd0, 4'd1, 2'd3, 6'b001000), 1'b1, 1'b1);
        waitDrain(20);

        // only lane 1 valid: compacted into lane 0
        mask_q.push_back(2'b01);
        applyStimulus(2'b10, L(4'd0, 3'd0, 2'd0, 4'd0, 2'd0, 6'b000000),
                             L(4'd6, 3'd3, 2'd3, 4'd2, 2'd1, 6'b110000), 1'b1, 1'b1);
        waitDrain(20);

        // stall the consumer, fill to count=3, try a push while not ready, then drain across wrap
        out_ready = 1'b0;
        mask_q.push_back(2'b11);
        mask_q.push_back(2'b11);
        mask_q.push_back(2'b01);
        applyStimulus(2'b11, L(4'd8, 3'd0, 2'd0, 4'd0, 2'd0, 6'b000000),
                             L(4'd9, 3'd1, 2'd2, 4'd15, 2'd0, 6'b110000), 1'b1, 1'b1);
        applyStimulus(2'b11, L(4'd10, 3'd2, 2'd3, 4'd2, 2'd3, 6'b110000),
                             L(4'd11, 3'd5, 2'd0, 4'd4, 2'd1, 6'b001000), 1'b1, 1'b1);
        applyStimulus(2'b01, L(4'd12, 3'd3, 2'd1, 4'd3, 2'd2, 6'b110000),
                             L(4'd0, 3'd0, 2'd0, 4'd0, 2'd0, 6'b000000), 1'b1, 1'b1);
        applyStimulus(2'b11, L(4'd13, 3'd1, 2'd1, 4'd1, 2'd0, 6'b110000),
                             L(4'd14, 3'd1, 2'd1, 4'd1, 2'd0, 6'b110000), 1'b0, 1'b0);
        checkOutput("stalled out_valid held", 64'(out_valid), 64'd3);
        checkOutput("stalled in_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        waitDrain(20);

        // fill completely with a stalled bundle, then flush
        out_ready = 1'b0;
        applyStimulus(2'b11, L(4'd1, 3'd1, 2'd1, 4'd1, 2'd0, 6'b110000),
                             L(4'd2, 3'd2, 2'd1, 4'd1, 2'd1, 6'b110000), 1'b1, 1'b0);
        applyStimulus(2'b11, L(4'd3, 3'd3, 2'd1, 4'd1, 2'd0, 6'b110000),
                             L(4'd4, 3'd4, 2'd1, 4'd1, 2'd1, 6'b101100), 1'b1, 1'b0);
        applyStimulus(2'b11, L(4'd5, 3'd5, 2'd1, 4'd1, 2'd0, 6'b001000),
                             L(4'd6, 3'd1, 2'd1, 4'd1, 2'd1, 6'b110000), 1'b1, 1'b0);
        checkOutput("full in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        applyStimulus(2'b11, L(4'd7, 3'd1, 2'd1, 4'd1, 2'd0, 6'b110000),
                             L(4'd8, 3'd1, 2'd1, 4'd1, 2'd0, 6'b110000), 1'b0, 1'b0);
        flush = 1'b0;
        checkOutput("flush out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush in_ready", 64'(in_ready), 64'd1);

        // a push in a flush cycle is dropped even when in_ready is high
        flush = 1'b1;
        applyStimulus(2'b11, L(4'd9, 3'd1, 2'd1, 4'd1, 2'd0, 6'b110000),
                             L(4'd10, 3'd1, 2'd1, 4'd1, 2'd0, 6'b110000), 1'b1, 1'b0);
        flush = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("post-flush out_valid", 64'(out_valid), 64'd0);
        checkOutput("post-flush in_ready", 64'(in_ready), 64'd1);

        // queue still works from the cleared pointers; BR as last lane
        mask_q.push_back(2'b11);
        applyStimulus(2'b11, L(4'd0, 3'd1, 2'd0, 4'd7, 2'd0, 6'b110000),
                             L(4'd1, 3'd6, 2'd0, 4'd10, 2'd0, 6'b000010), 1'b1, 1'b1);
        waitDrain(20);

        // asynchronous reset in mid-cycle discards a presented bundle
        out_ready = 1'b0;
        applyStimulus(2'b11, L(4'd2, 3'd2, 2'd1, 4'd2, 2'd1, 6'b110000),
                             L(4'd3, 3'd3, 2'd2, 4'd3, 2'd2, 6'b110000), 1'b1, 1'b0);
        tick();
        checkOutput("pre-reset out_valid", 64'(out_valid), 64'd3);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("async reset in_ready", 64'(in_ready), 64'd1);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        checkOutput("after reset out_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
